// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants, lane keep-mask helper and
// assembly states for the FIFO read-side packer.
package fifo_pkg;

  localparam int FIFO_DW     = 8;
  localparam int FIFO_RD_LAT = 1;

  typedef enum logic {
    FILL,
    HOLD
  } asm_state_e;

  // Low cnt bits set; valid for cnt in 0..8.
  function automatic logic [7:0] keep_mask(
    input logic [3:0] cnt
  );
    return 8'((9'd1 << cnt) - 9'd1);
  endfunction

endpackage

// File: rtl/fifo_pack_outreg.sv
// fifo_pack_outreg: valid/ready holding register for the packed word.
// Ports: clk, rst_n, i_load/i_data in, o_free, o_valid/o_data out, i_ready in.
module fifo_pack_outreg #(
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  output logic         o_free,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Free when empty or draining this cycle, so words can go back-to-back.
  assign o_free  = !r_valid | i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops DW-bit FIFO entries and packs PACK of them per word.
// Ports: rd_clk, rst_n; FIFO side fifo_empty, fifo_rd, fifo_data;
//   flush pulse; stream m_valid, m_ready, m_data, m_keep, m_last; busy.
// Optional idle auto-flush after TO_CYC cycles: define FIFO_PACK_FLUSH_EN.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DW     = FIFO_DW,
  parameter int PACK   = 4,
  parameter int TO_CYC = 16
) (
  input  logic               rd_clk,
  input  logic               rst_n,
  input  logic               fifo_empty,
  output logic               fifo_rd,
  input  logic [DW-1:0]      fifo_data,
  input  logic               flush,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DW*PACK-1:0] m_data,
  output logic [PACK-1:0]    m_keep,
  output logic               m_last,
  output logic               busy
);

  localparam int OW = DW * PACK;
  localparam int CW = $clog2(PACK + 1);
  localparam int PW = OW + PACK + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(PACK);
  localparam logic [CW-1:0] CNT_LAST = CW'(PACK - 1);

  if (PACK < 2 || PACK > 8 || TO_CYC < 1 || FIFO_RD_LAT != 1) begin : g_bad
    $error("fifo_rd_packer: unsupported parameters");
  end

  asm_state_e    r_state;
  asm_state_e    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_pend;
  logic          r_run;
  logic          r_flush_pend;
  logic [DW-1:0] r_lane [PACK];

  logic          w_fill;
  logic          w_hold;
  logic          w_load;
  logic          w_out_free;
  logic          w_to;
  logic          w_flush_req;
  logic          w_flush_go;
  logic          w_flush_nop;
  logic          w_full_cap;
  logic [CW:0]   w_inflight;
  logic [PACK-1:0] w_keep;
  logic [OW-1:0] w_word;
  logic          w_last;
  logic [PW-1:0] w_out;

  assign w_fill = (r_state == FILL);

  // Lanes already filled plus the one byte that may be in flight.
  assign w_inflight = {1'b0, r_cnt} + {{CW{1'b0}}, r_pend};

  // r_run keeps pops off until the first edge after reset release.
  assign fifo_rd = r_run & !fifo_empty & !w_hold
                 & (w_inflight < (CW+1)'(PACK));

  assign w_flush_req = flush | r_flush_pend | w_to;
  assign w_flush_go  = w_fill & w_flush_req & (r_cnt != '0) & !r_pend;
  assign w_flush_nop = w_fill & w_flush_req & (r_cnt == '0) & !r_pend;
  assign w_full_cap  = w_fill & r_pend & (r_cnt == CNT_LAST);

  // A flush closing the word also blocks this cycle's pop, so no byte
  // can arrive while the partial word waits in HOLD.
  always_comb begin
    w_state_nxt = r_state;
    w_hold      = 1'b0;
    w_load      = 1'b0;
    unique case (r_state)
      FILL: begin
        w_hold = w_flush_go;
        if (w_flush_go || w_full_cap) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        w_hold = 1'b1;
        w_load = w_out_free;
        if (w_out_free) begin
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FILL;
      r_run        <= 1'b0;
      r_pend       <= 1'b0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= 1'b1;
      r_pend  <= fifo_rd;
      if (w_fill && r_pend) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (w_load) begin
        r_cnt <= {{(CW-1){1'b0}}, r_pend};
      end
      // A full word swallows any flush still waiting.
      if (w_flush_go || w_flush_nop || w_full_cap) begin
        r_flush_pend <= 1'b0;
      end else if (w_flush_req) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PACK; i++) begin
        r_lane[i] <= '0;
      end
    end else if (r_pend) begin
      for (int i = 0; i < PACK; i++) begin
        if ((w_fill && r_cnt == CW'(i)) || (w_load && i == 0)) begin
          r_lane[i] <= fifo_data;
        end
      end
    end
  end

  assign w_keep = PACK'(keep_mask(4'(r_cnt)));
  assign w_last = (r_cnt != CNT_FULL);

  always_comb begin
    w_word = '0;
    for (int i = 0; i < PACK; i++) begin
      if (w_keep[i]) begin
        w_word[i*DW +: DW] = r_lane[i];
      end
    end
  end

`ifdef FIFO_PACK_FLUSH_EN
  localparam int TW = $clog2(TO_CYC + 1);

  logic [TW-1:0] r_idle;
  logic          w_idle_run;

  assign w_idle_run = w_fill & (r_cnt != '0) & !r_pend & fifo_empty;
  assign w_to       = w_idle_run & (r_idle == TW'(TO_CYC - 1));

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle <= '0;
    end else if (!w_idle_run || w_to) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + TW'(1);
    end
  end
`else
  assign w_to = 1'b0;
`endif

  fifo_pack_outreg #(
    .W(PW)
  ) u_outreg (
    .clk    (rd_clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_data ({w_last, w_keep, w_word}),
    .o_free (w_out_free),
    .o_valid(m_valid),
    .i_ready(m_ready),
    .o_data (w_out)
  );

  assign m_data = w_out[OW-1:0];
  assign m_keep = w_out[OW +: PACK];
  assign m_last = w_out[PW-1];

  assign busy = (r_cnt != '0) | r_pend | m_valid;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: FIFO model, word scoreboard, vector table
// and hand sequences for the read-side packer.
module tb_fifo_rd_packer;

  typedef struct {
    logic [31:0] b;
    int          n;
    logic        fl;
    logic [31:0] ed;
    logic [3:0]  ek;
    logic        el;
  } vec_t;

  logic        rd_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty;
  logic        fifo_rd;
  logic [7:0]  fifo_data = 8'h00;
  logic        flush = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic        busy;

  logic        q_empty = 1'b1;
  logic        force_ne = 1'b0;
  logic        rd_neg = 1'b0;
  logic [7:0]  fq [$];
  logic [7:0]  inq [$];
  logic [36:0] sb [$];
  int          n_chk = 0;
  int          n_err = 0;
  int          n_pop = 0;

  always #5 rd_clk = ~rd_clk;

  assign fifo_empty = force_ne ? 1'b0 : q_empty;

  fifo_rd_packer dut (
    .rd_clk    (rd_clk),
    .rst_n     (rst_n),
    .fifo_empty(fifo_empty),
    .fifo_rd   (fifo_rd),
    .fifo_data (fifo_data),
    .flush     (flush),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_keep    (m_keep),
    .m_last    (m_last),
    .busy      (busy)
  );

  // FIFO model: one-cycle read latency, pop strobe sampled at negedge.
  always @(posedge rd_clk) begin
    if (rd_neg) begin
      if (fq.size() > 0) fifo_data <= fq.pop_front();
      n_pop++;
    end
    while (inq.size() > 0) fq.push_back(inq.pop_front());
    q_empty <= (fq.size() == 0);
  end

  always @(negedge rd_clk) begin
    logic [36:0] exp;
    rd_neg = fifo_rd;
    n_chk++;
    if (fifo_rd && fifo_empty) begin
      n_err++;
      $display("FAIL pop_when_empty: fifo_rd=1 while fifo_empty=1");
    end
    if (m_valid && m_ready) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_word: got last=%b keep=%h data=%h, required none",
                 m_last, m_keep, m_data);
      end else begin
        exp = sb.pop_front();
        if ({m_last, m_keep, m_data} !== exp) begin
          n_err++;
          $display("FAIL word: got last=%b keep=%h data=%h, required last=%b keep=%h data=%h",
                   m_last, m_keep, m_data, exp[36], exp[35:32], exp[31:0]);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic wait_pops(input int target, input int lim, input string nm);
    int k = 0;
    while (n_pop < target && k < lim) begin
      tick();
      k++;
    end
    check(nm, 64'(n_pop), 64'(target));
  endtask

  task automatic wait_sb(input int lim, input string nm);
    int k = 0;
    while (sb.size() != 0 && k < lim) begin
      tick();
      k++;
    end
    check(nm, 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_idle(input int lim, input string nm);
    int k = 0;
    while (busy && k < lim) begin
      tick();
      k++;
    end
    check(nm, 64'(busy), 64'd0);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic push_word(input logic l, input logic [3:0] k,
                           input logic [31:0] d);
    sb.push_back({l, k, d});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [5];
    int   base;
    tbl[0] = '{32'h44332211, 4, 1'b0, 32'h44332211, 4'hF, 1'b0};
    tbl[1] = '{32'h0000BBAA, 2, 1'b1, 32'h0000BBAA, 4'h3, 1'b1};
    tbl[2] = '{32'h0000007E, 1, 1'b1, 32'h0000007E, 4'h1, 1'b1};
    tbl[3] = '{32'h00030201, 3, 1'b1, 32'h00030201, 4'h7, 1'b1};
    tbl[4] = '{32'hEFBEADDE, 4, 1'b0, 32'hEFBEADDE, 4'hF, 1'b0};

    // Reset held while the empty flag toggles.
    for (int i = 0; i < 6; i++) begin
      force_ne = i[0];
      #2;
      check("rst_fifo_rd", 64'(fifo_rd), 64'd0);
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      tick();
    end
    force_ne = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rel_fifo_rd", 64'(fifo_rd), 64'd0);
      check("rel_m_valid", 64'(m_valid), 64'd0);
      check("rel_out", 64'({m_last, m_keep, m_data}), 64'd0);
      check("rel_busy", 64'(busy), 64'd0);
    end

    m_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      base = n_pop;
      push_word(tbl[v].el, tbl[v].ek, tbl[v].ed);
      for (int j = 0; j < tbl[v].n; j++) inq.push_back(tbl[v].b[j*8 +: 8]);
      wait_pops(base + tbl[v].n, 50, "vec_pop_wait");
      if (tbl[v].fl) begin
        repeat (3) tick();
        pulse_flush();
      end
      wait_sb(60, "vec_word_out");
      wait_idle(20, "vec_idle");
      check("vec_pops", 64'(n_pop - base), 64'(tbl[v].n));
    end

    // Back-pressure: two words fill, then pops stop.
    m_ready = 1'b0;
    base = n_pop;
    push_word(1'b0, 4'hF, 32'h04030201);
    push_word(1'b0, 4'hF, 32'h08070605);
    push_word(1'b0, 4'hF, 32'h0C0B0A09);
    for (int k = 1; k <= 12; k++) inq.push_back(8'(k));
    repeat (20) tick();
    check("bp_pops_stalled", 64'(n_pop - base), 64'd8);
    check("bp_valid", 64'(m_valid), 64'd1);
    check("bp_data_held", 64'(m_data), 64'h04030201);
    m_ready = 1'b1;
    wait_sb(80, "bp_words");
    wait_idle(20, "bp_idle");
    check("bp_pops_total", 64'(n_pop - base), 64'd12);

    // Flush with nothing held.
    pulse_flush();
    repeat (10) tick();
    check("noop_flush_valid", 64'(m_valid), 64'd0);
    check("noop_flush_busy", 64'(busy), 64'd0);

    // Flush in the cycle the 4th byte is captured.
    base = n_pop;
    push_word(1'b0, 4'hF, 32'h8D7C6B5A);
    inq.push_back(8'h5A);
    inq.push_back(8'h6B);
    inq.push_back(8'h7C);
    inq.push_back(8'h8D);
    wait_pops(base + 4, 50, "cap4_pop_wait");
    pulse_flush();
    wait_sb(40, "cap4_word");
    wait_idle(20, "cap4_idle");
    repeat (5) tick();
    check("cap4_no_extra", 64'(m_valid), 64'd0);

    // Reset with a pop in flight; next word starts at lane 0.
    base = n_pop;
    inq.push_back(8'hF1);
    inq.push_back(8'hF2);
    inq.push_back(8'hF3);
    inq.push_back(8'hF4);
    wait_pops(base + 2, 50, "rstmid_pop_wait");
    rst_n = 1'b0;
    #1;
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_valid", 64'(m_valid), 64'd0);
    tick();
    push_word(1'b0, 4'hF, 32'h2615F4F3);
    inq.push_back(8'h15);
    inq.push_back(8'h26);
    tick();
    rst_n = 1'b1;
    wait_sb(60, "rstmid_word");
    wait_idle(20, "rstmid_idle");
    check("rstmid_pops", 64'(n_pop - base), 64'd6);

    // Idle timeout behaviour.
    inq.push_back(8'h01);
    inq.push_back(8'h02);
    inq.push_back(8'h03);
`ifdef FIFO_PACK_FLUSH_EN
    push_word(1'b1, 4'h7, 32'h00030201);
    wait_sb(60, "to_word");
`else
    repeat (40) tick();
    check("to_none_valid", 64'(m_valid), 64'd0);
    check("to_busy_held", 64'(busy), 64'd1);
    push_word(1'b1, 4'h7, 32'h00030201);
    pulse_flush();
    wait_sb(20, "to_manual_flush");
`endif
    wait_idle(20, "to_idle");

    repeat (5) tick();
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
